// File: rtl/detector_padrao.sv
// -----------------------------------------------------------------------------
// detector_padrao
// Serial pattern detector. Shifts a gated serial bit stream into a WIDTH-bit
// window and compares it against a programmable pattern, either once
// (one-shot, found held) or continuously (found pulses, matches counted).
//
// Parameters
//   WIDTH    pattern length in bits (2..32)
//   CNT_W    match counter width (1..16), counter saturates
//   OVERLAP  1: overlapping matches count in continuous mode
//            0: WIDTH fresh bits are needed after each match
//
// Build option
//   DETECTOR_MASK_EN  when defined, i_mask is latched on load and bits with a
//                     0 mask are ignored in the compare; otherwise the compare
//                     is exact and i_mask is unused.
//
// Ports
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   i_load          latch pattern/mask, abort any search
//   i_pattern       pattern, bit WIDTH-1 is the oldest bit
//   i_mask          compare mask (1 = compare bit)
//   i_start         begin a new search (clears count)
//   i_stop          abort a running search, keep count
//   i_mode_cont     0 one-shot, 1 continuous; sampled on start
//   i_bit_valid     i_bit_in is meaningful this cycle
//   i_bit_in        serial data, newest bit
//   o_found         one-shot: level; continuous: 1-cycle pulse per match
//   o_busy          search active
//   o_match_count   matches since last start, saturating
// -----------------------------------------------------------------------------
module detector_padrao #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [WIDTH-1:0] i_mask,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode_cont,
    input  logic             i_bit_valid,
    input  logic             i_bit_in,
    output logic             o_found,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_match_count
);

    // fill counter spans 0..WIDTH
    localparam int FW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           r_state,   w_state_nx;
    logic [WIDTH-1:0] r_pattern, w_pattern_nx;
    logic [WIDTH-1:0] r_shift,   w_shift_nx;
    logic [FW-1:0]    r_fill,    w_fill_nx;
    logic             r_mode,    w_mode_nx;
    logic             r_found,   w_found_nx;
    logic [CNT_W-1:0] r_count,   w_count_nx;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_window;
    logic             w_match;

`ifdef DETECTOR_MASK_EN
    logic [WIDTH-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mask <= '1;
        else if (i_load)
            r_mask <= i_mask;
    end

    assign w_mask = r_mask;
`else
    // exact compare: mask is constant all ones and the input is not used
    logic [WIDTH-1:0] w_unused_mask;
    assign w_unused_mask = i_mask;
    assign w_mask        = '1;
`endif

    // the window includes the bit being presented this cycle
    assign w_window = {r_shift[WIDTH-2:0], i_bit_in};

    // r_fill counts bits already held; the incoming bit completes WIDTH
    assign w_match  = (((w_window ^ r_pattern) & w_mask) == '0) &&
                      (r_fill >= FW'(WIDTH - 1));

    always_comb begin
        w_state_nx   = r_state;
        w_pattern_nx = r_pattern;
        w_shift_nx   = r_shift;
        w_fill_nx    = r_fill;
        w_mode_nx    = r_mode;
        w_found_nx   = r_found;
        w_count_nx   = r_count;

        if (i_load) begin
            w_pattern_nx = i_pattern;
            w_state_nx   = IDLE;
            w_found_nx   = 1'b0;
        end else if (i_stop && (r_state == SEARCH)) begin
            w_state_nx = IDLE;
            w_found_nx = 1'b0;
        end else if (i_start) begin
            // any bit presented alongside start is dropped
            w_shift_nx = '0;
            w_fill_nx  = '0;
            w_count_nx = '0;
            w_found_nx = 1'b0;
            w_mode_nx  = i_mode_cont;
            w_state_nx = SEARCH;
        end else if (r_state == SEARCH) begin
            // continuous-mode found is a single-cycle pulse
            if (r_mode)
                w_found_nx = 1'b0;

            if (i_bit_valid) begin
                w_shift_nx = w_window;
                if (r_fill != FW'(WIDTH))
                    w_fill_nx = r_fill + 1'b1;

                if (w_match) begin
                    w_found_nx = 1'b1;
                    if (!r_mode) begin
                        w_count_nx = CNT_W'(1);
                        w_state_nx = DONE;
                    end else begin
                        if (r_count != '1)
                            w_count_nx = r_count + 1'b1;
                        // without overlap the next match needs a full new window
                        if (OVERLAP == 0)
                            w_fill_nx = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_shift   <= '0;
            r_fill    <= '0;
            r_mode    <= 1'b0;
            r_found   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_pattern <= w_pattern_nx;
            r_shift   <= w_shift_nx;
            r_fill    <= w_fill_nx;
            r_mode    <= w_mode_nx;
            r_found   <= w_found_nx;
            r_count   <= w_count_nx;
        end
    end

    assign o_found       = r_found;
    assign o_busy        = (r_state == SEARCH);
    assign o_match_count = r_count;

endmodule

// File: doc/detector_padrao.md
# detector_padrao

Parametrised serial pattern detector: next generation of the single-byte sequence finder in the serial-input path. Matches a WIDTH-bit programmable pattern against a gated serial bit stream, in one-shot or continuous mode, with optional overlap and a saturating match counter. Sits between the bit deserialiser front end and the control FSM, which programs the pattern, starts searches and reads results.

## Interface
- WIDTH, 8: pattern length in bits, legal range 2..32.
- CNT_W, 8: match counter width, legal range 1..16.
- OVERLAP, 1: 1 = in continuous mode, overlapping matches count; 0 = after a match, WIDTH fresh bits are required.

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  latch pattern/mask, abort any search.
- pattern  in  WIDTH  pattern; bit WIDTH-1 is the oldest bit.
- mask  in  WIDTH  1 = compare this bit; ignored unless the macro is defined.
- start  in  1  begin a new search.
- stop  in  1  abort the current search, keep the count.
- mode_cont  in  1  0 = one-shot, 1 = continuous; sampled only on start.
- bit_valid  in  1  bit_in is meaningful this cycle.
- bit_in  in  1  serial data, newest bit.
- found  out  1  one-shot: level; continuous: 1-cycle pulse per match.
- busy  out  1  search active.
- match_count  out  CNT_W  matches since last start, saturating.

## Operation
- States: IDLE, SEARCH, DONE. Internal registers: pattern_reg, mask_reg, shift_reg[WIDTH-1:0], fill_cnt (0..WIDTH, saturating), mode_reg.
- Reset values: found=0, busy=0, match_count=0, state IDLE, shift_reg=0, fill_cnt=0, pattern_reg=0, mask_reg=all ones.
- Priority within one cycle: load > stop > start > bit processing.
- load, any state: pattern_reg<=pattern, mask_reg<=mask, go to IDLE, found=0, busy=0. match_count is unchanged.
- stop: if in SEARCH, go to IDLE, busy=0, found=0, match_count kept. In IDLE or DONE, stop has no effect.
- start, any state: shift_reg=0, fill_cnt=0, match_count=0, found=0, mode_reg<=mode_cont, go to SEARCH, busy=1. A bit_in presented in the start cycle is discarded.
- SEARCH with bit_valid=1:
  - window = {shift_reg[WIDTH-2:0], bit_in}; shift_reg<=window; fill_cnt increments.
  - A match is (window ^ pattern_reg) & mask_reg == 0 and fill_cnt+1 >= WIDTH. No match is possible before WIDTH valid bits since start.
- Match handling:
  - One-shot: found<=1 (held), match_count<=1, go to DONE, busy<=0.
  - Continuous: found pulses 1 cycle; match_count increments, saturating at 2^CNT_W-1. If OVERLAP=0, fill_cnt<=0.
- SEARCH with bit_valid=0: state and registers hold. In continuous mode, found returns to 0.
- DONE: holds found=1 until the next load, start or reset. bit_valid is ignored.
- IDLE: bit_valid is ignored.

## Timing
- Match latency: found and match_count update at the clock edge that samples the completing bit, and are visible the following cycle.
- Back-to-back valid bits are supported every cycle; no backpressure exists.
- busy rises the cycle after start and falls the cycle after a one-shot match, stop or load.
- Reset mid-search: the next edge with rst_n=0 restores all reset values.

## Configuration
- DETECTOR_MASK_EN defined: mask is latched on load and applied in the compare.
- DETECTOR_MASK_EN undefined: mask_reg is held at all ones, the mask input is unused, and the compare is exact on all WIDTH bits.

## Test plan
- WIDTH=8, load 8'hA5, start one-shot, stream 8 ones then 1,0,1,0,0,1,0,1 -> found=1 the cycle after the 16th bit and held; busy=0; match_count=1.
- Load 8'h00, start, stream 7 zeros -> found stays 0. 8th zero -> found=1.
- Continuous, pattern 8'hAA, stream 1010101010 -> OVERLAP=1: 2 found pulses, match_count=2; OVERLAP=0: 1 pulse, match_count=1.
- Same stream as scenario 1 with bit_valid low every other cycle -> identical found and match_count, match delayed by the gap cycles.
- Macro defined, pattern 8'hF0, mask 8'hF0, stream 11110110 -> found=1. Macro undefined -> found=0.
- CNT_W=2, continuous, 5 matches -> match_count=3. load mid-search -> busy=0, found=0, count kept. rst_n=0 mid-search -> all outputs 0.
